serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (WIDTH >= 2).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request an addition; sampled only when busy = 0.
REQ-005 a  input  WIDTH  first operand, unsigned/two's-complement agnostic.
REQ-006 b  input  WIDTH  second operand.
REQ-007 cin  input  1  carry-in for bit 0.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  single-cycle pulse marking valid results.
REQ-010 sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry out of bit WIDTH-1.
REQ-012 overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 IDLE or DONE with start = 1 at edge E0: latch a and b into the operand shift registers, load cin into the carry register, clear the bit counter, and go to SHIFT.
REQ-015 IDLE with start = 0 SHALL remain in IDLE; DONE with start = 0 SHALL go to IDLE.
REQ-016 In each SHIFT cycle, one full adder SHALL add the operand LSBs and the carry register, shift the sum bit into the partial-sum MSB, shift both operands right by one, update the carry register, and increment the counter.
REQ-017 After exactly WIDTH SHIFT edges (E1..E_WIDTH), the block SHALL load sum, cout and overflow at E_WIDTH and enter DONE.
REQ-018 done SHALL be high only in DONE; its first high cycle follows edge E_WIDTH, giving a fixed latency of WIDTH edges from the start-sampling edge.
REQ-019 busy SHALL be high exactly in SHIFT.
REQ-020 sum, cout and overflow SHALL hold their values from the DONE load until the next completion; partial results SHALL never appear on them.
REQ-021 start asserted while busy = 1 SHALL be ignored and SHALL NOT be queued.
REQ-022 Changes on a, b and cin while busy = 1 SHALL NOT affect the result in progress.
REQ-023 start held high continuously SHALL produce back-to-back additions, one every WIDTH+1 cycles, each with a one-cycle done pulse.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.

Reset
REQ-025 While reset = 1 at a rising edge: state = IDLE, busy = 0, done = 0, sum = 0, cout = 0, overflow = 0, and the counter, carry and shift registers = 0.
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; reset has priority over start.
REQ-027 start sampled on the first edge after reset deasserts SHALL be accepted normally.

Structure
REQ-028 The state encodings (IDLE, SHIFT, DONE) SHALL be shared constants in the common definitions include file; WIDTH stays a module parameter.
REQ-029 The per-bit addition SHALL instantiate the existing fullAdder module once; no other sub-module.
REQ-030 The implementation SHALL contain no combinational path from start, a or b to any output.

Verification (WIDTH = 8)
REQ-031 a=0x0F, b=0x01, cin=0, start pulse -> done exactly 8 edges after the start edge; sum=0x10, cout=0, overflow=0.
REQ-032 a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, overflow=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1.
REQ-033 a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, overflow=1; busy high for exactly 8 cycles.
REQ-034 Start 0x01+0x01, then at E3 pulse start with 0xFF+0xFF and change a/b -> single done pulse, sum=0x02; second request is dropped.
REQ-035 Assert reset at E4 of an operation -> no done pulse; all outputs 0 next cycle; a new start after reset -> correct result at normal latency.
REQ-036 start held high with alternating operand pairs 0x12+0x34 and 0xF0+0x0F -> done every 9 cycles; sum=0x46, then 0xFF, with cout=0 for both.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and a
// helper that sizes the bit counter.
package serial_adder_pkg;

    // Controller states; the encodings are shared so other blocks and
    // benches can decode the state consistently.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // The counter must hold values 0..width so it never wraps mid-operation.
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder used by the serial datapath, one bit per cycle.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first, one bit per clock,
// and presents the registered result with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int            CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    // Only WIDTH-1 partial bits are kept: the final bit comes straight from
    // the full adder on the last shift edge.
    logic [WIDTH-2:0] psum_reg, psum_next;
    logic [WIDTH-1:0] psum_shift;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    logic load;
    logic shift;
    logic finish;
    logic fa_sum;
    logic fa_cout;

    fullAdder u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_reg == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values: load operands, shift one bit, or commit result.
    always_comb begin
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        psum_next  = psum_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;
        psum_shift = {fa_sum, psum_reg};
        if (load) begin
            a_sh_next  = a;
            b_sh_next  = b;
            psum_next  = '0;
            carry_next = cin;
            cnt_next   = '0;
        end else if (shift) begin
            a_sh_next  = a_sh_reg >> 1;
            b_sh_next  = b_sh_reg >> 1;
            psum_next  = psum_shift[WIDTH-1:1];
            carry_next = fa_cout;
            cnt_next   = cnt_reg + CW'(1);
        end
        // On the last bit the carry register holds the carry into the MSB.
        if (finish) begin
            sum_next  = psum_shift;
            cout_next = fa_cout;
            ovf_next  = carry_reg ^ fa_cout;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            psum_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            psum_reg  <= psum_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign busy     = (state_reg == SHIFT);
    assign done     = (state_reg == DONE);
    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH = 8): latency, results, flags,
// ignored start while busy, mid-operation reset and back-to-back operation.
module tb_serial_adder;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    int n_checks;
    int n_fail;
    logic [7:0] held_sum;
    logic       held_cout;
    logic       held_ovf;

    serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; issues a one-cycle start, checks latency,
    // busy width, held outputs during the operation and the final result.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tc, input logic [7:0] es, input logic ec, input logic eo);
        int k;
        int busy_cnt;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(posedge clk);               // E0
        @(negedge clk);
        start = 1'b0;
        k = 0;
        busy_cnt = 0;
        while (!done && k < 20) begin
            if (busy) busy_cnt++;
            check({tag, " sum_held"}, {24'd0, sum}, {24'd0, held_sum});
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, 8);
        check({tag, " busy_cycles"}, busy_cnt, 8);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " sum"}, {24'd0, sum}, {24'd0, es});
        check({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, " overflow"}, {31'd0, overflow}, {31'd0, eo});
        held_sum = es; held_cout = ec; held_ovf = eo;
        @(negedge clk);
        check({tag, " done_pulse_ends"}, {31'd0, done}, 32'd0);
        check({tag, " sum_holds"}, {24'd0, sum}, {24'd0, es});
    endtask

    initial begin
        int k;
        int done_seen;
        int idx;
        int exp_time [3];
        logic [7:0] exp_sum [3];
        logic toggle;

        n_checks = 0; n_fail = 0;
        held_sum = 8'h00; held_cout = 1'b0; held_ovf = 1'b0;
        reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset sum", {24'd0, sum}, 32'd0);
        check("reset cout", {31'd0, cout}, 32'd0);
        check("reset overflow", {31'd0, overflow}, 32'd0);

        // Start on the very first edge after reset release.
        reset = 1'b0;
        run_op("op_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op("op_ff_00_c1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("op_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("op_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Start while busy is ignored and operand changes do not disturb.
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);               // E0
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);               // between E2 and E3
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(negedge clk);               // after E3
        start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                done_seen++;
                check("busy_start sum", {24'd0, sum}, 32'h02);
                check("busy_start cout", {31'd0, cout}, 32'd0);
            end
        end
        check("busy_start done_count", done_seen, 1);
        check("busy_start idle_after", {31'd0, busy}, 32'd0);
        held_sum = 8'h02;

        // Reset asserted at E4 of an operation aborts it.
        a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(posedge clk);               // E0
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);               // between E3 and E4
        reset = 1'b1;
        @(negedge clk);               // after E4
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort sum", {24'd0, sum}, 32'd0);
        check("abort cout", {31'd0, cout}, 32'd0);
        check("abort overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort no_done", done_seen, 0);
        held_sum = 8'h00;
        run_op("after_reset", 8'h55, 8'h22, 1'b1, 8'h78, 1'b0, 1'b0);

        // start held high: back-to-back additions every 9 cycles.
        exp_time[0] = 8;  exp_sum[0] = 8'h46;
        exp_time[1] = 17; exp_sum[1] = 8'hFF;
        exp_time[2] = 26; exp_sum[2] = 8'h46;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);               // E0
        @(negedge clk);
        a = 8'hF0; b = 8'h0F;
        idx = 0; toggle = 1'b0;
        for (k = 0; k < 27; k++) begin
            if (done) begin
                if (idx < 3) begin
                    check("b2b time", k, exp_time[idx]);
                    check("b2b sum", {24'd0, sum}, {24'd0, exp_sum[idx]});
                    check("b2b cout", {31'd0, cout}, 32'd0);
                end
                idx++;
                toggle = 1'b1;
            end else if (toggle) begin
                // Operands latched at the previous edge; queue the other pair.
                if (a == 8'h12) begin a = 8'hF0; b = 8'h0F; end
                else begin a = 8'h12; b = 8'h34; end
                toggle = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b done_count", idx, 3);
        start = 1'b0;
        // Drain the operation started at the last DONE edge.
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("b2b drain done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("b2b final idle", {31'd0, done | busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
